// File: rtl/sm3_pad_core.sv
// SM3 message padder: passes message words through, then appends 0x80, zero fill and the 64-bit bit length.
// Optional feature macro SM3_PAD_LEN_OVF_EN adds the sticky length-overflow flag pad_len_ovf_o.
module sm3_pad_core #(
    parameter int unsigned LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] msg_inpt_d_i,
    input  logic        msg_inpt_vld_i,
    input  logic        msg_inpt_lst_i,
    input  logic [2:0]  msg_inpt_nb_i,
    output logic        msg_inpt_rdy_o,
    output logic [31:0] pad_otpt_d_o,
    output logic        pad_otpt_vld_o,
    output logic        pad_otpt_lst_o,
    input  logic        pad_otpt_rdy_i
`ifdef SM3_PAD_LEN_OVF_EN
    ,
    output logic        pad_len_ovf_o
`endif
);

    localparam int unsigned WCNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MSG,
        ST_PAD1,
        ST_PADZ,
        ST_LENH,
        ST_LENL
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [LEN_W-1:0]    len_q, len_d;

    logic                pass_c;
    logic                in_xfer_c;
    logic                out_xfer_c;
    logic                nb_four_c;
    logic [4:0]          sh_c;
    logic [31:0]         pad_word_c;
    logic [5:0]          add_bits_c;
    logic [63:0]         len64_c;
    logic [WCNT_W-1:0]   wcnt_inc_c;

    assign pass_c     = (state_q == ST_IDLE) || (state_q == ST_MSG);
    assign in_xfer_c  = pass_c && msg_inpt_vld_i && pad_otpt_rdy_i;
    assign out_xfer_c = pad_otpt_vld_o && pad_otpt_rdy_i;
    assign nb_four_c  = (msg_inpt_nb_i >= 3'd4);
    assign sh_c       = {msg_inpt_nb_i[1:0], 3'b000};
    // Keep the nb leading bytes, place 0x80 right after them, zero the rest.
    assign pad_word_c = (msg_inpt_d_i & ~(32'hFFFF_FFFF >> sh_c)) | (32'h8000_0000 >> sh_c);
    assign add_bits_c = (!msg_inpt_lst_i || nb_four_c) ? 6'd32 : {1'b0, msg_inpt_nb_i[1:0], 3'b000};
    assign len64_c    = 64'(len_q);
    assign wcnt_inc_c = wcnt_q + WCNT_W'(1);

    // Output datapath: pass-through in IDLE/MSG, register-driven in the pad states.
    always_comb begin
        msg_inpt_rdy_o = 1'b0;
        pad_otpt_vld_o = 1'b0;
        pad_otpt_lst_o = 1'b0;
        pad_otpt_d_o   = msg_inpt_d_i;
        case (state_q)
            ST_IDLE, ST_MSG: begin
                msg_inpt_rdy_o = pad_otpt_rdy_i;
                pad_otpt_vld_o = msg_inpt_vld_i;
                pad_otpt_d_o   = (msg_inpt_lst_i && !nb_four_c) ? pad_word_c : msg_inpt_d_i;
            end
            ST_PAD1: begin
                pad_otpt_vld_o = 1'b1;
                pad_otpt_d_o   = 32'h8000_0000;
            end
            ST_PADZ: begin
                pad_otpt_vld_o = 1'b1;
                pad_otpt_d_o   = 32'h0000_0000;
            end
            ST_LENH: begin
                pad_otpt_vld_o = 1'b1;
                pad_otpt_d_o   = len64_c[63:32];
            end
            ST_LENL: begin
                pad_otpt_vld_o = 1'b1;
                pad_otpt_lst_o = 1'b1;
                pad_otpt_d_o   = len64_c[31:0];
            end
            default: ;
        endcase
    end

`ifdef SM3_PAD_LEN_OVF_EN
    logic             ovf_q, ovf_d;
    logic [LEN_W:0]   sum_c;
    assign sum_c         = {1'b0, len_q} + (LEN_W+1)'(add_bits_c);
    assign pad_len_ovf_o = ovf_q;
`else
    logic [LEN_W-1:0] sum_c;
    assign sum_c = len_q + LEN_W'(add_bits_c);
`endif

    // Next-state, word index and length accumulation.
    always_comb begin
        state_d = state_q;
        wcnt_d  = out_xfer_c ? wcnt_inc_c : wcnt_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE, ST_MSG: begin
                if (in_xfer_c) begin
                    len_d = sum_c[LEN_W-1:0];
                    if (!msg_inpt_lst_i)          state_d = ST_MSG;
                    else if (nb_four_c)           state_d = ST_PAD1;
                    else if (wcnt_inc_c == 4'd14) state_d = ST_LENH;
                    else                          state_d = ST_PADZ;
                end
            end
            ST_PAD1: begin
                if (out_xfer_c) state_d = (wcnt_inc_c == 4'd14) ? ST_LENH : ST_PADZ;
            end
            ST_PADZ: begin
                if (out_xfer_c && wcnt_inc_c == 4'd14) state_d = ST_LENH;
            end
            ST_LENH: begin
                if (out_xfer_c) state_d = ST_LENL;
            end
            ST_LENL: begin
                if (out_xfer_c) begin
                    state_d = ST_IDLE;
                    len_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SM3_PAD_LEN_OVF_EN
    // Sticky wrap flag; the first word of a new message clears it before a fresh wrap can set it.
    always_comb begin
        ovf_d = ovf_q;
        if (in_xfer_c) ovf_d = ((state_q == ST_IDLE) ? 1'b0 : ovf_q) | sum_c[LEN_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_sm3_pad_core.sv
// Bench for sm3_pad_core: byte-level SM3 padding model against randomized handshakes and message lengths.
module tb_sm3_pad_core;

`ifdef SM3_PAD_LEN_OVF_EN
    localparam int unsigned LEN_W = 8;
`else
    localparam int unsigned LEN_W = 64;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] msg_inpt_d_i;
    logic        msg_inpt_vld_i;
    logic        msg_inpt_lst_i;
    logic [2:0]  msg_inpt_nb_i;
    logic        msg_inpt_rdy_o;
    logic [31:0] pad_otpt_d_o;
    logic        pad_otpt_vld_o;
    logic        pad_otpt_lst_o;
    logic        pad_otpt_rdy_i;
`ifdef SM3_PAD_LEN_OVF_EN
    logic        pad_len_ovf_o;
`endif

    sm3_pad_core #(.LEN_W(LEN_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .msg_inpt_d_i   (msg_inpt_d_i),
        .msg_inpt_vld_i (msg_inpt_vld_i),
        .msg_inpt_lst_i (msg_inpt_lst_i),
        .msg_inpt_nb_i  (msg_inpt_nb_i),
        .msg_inpt_rdy_o (msg_inpt_rdy_o),
        .pad_otpt_d_o   (pad_otpt_d_o),
        .pad_otpt_vld_o (pad_otpt_vld_o),
        .pad_otpt_lst_o (pad_otpt_lst_o),
        .pad_otpt_rdy_i (pad_otpt_rdy_i)
`ifdef SM3_PAD_LEN_OVF_EN
        ,
        .pad_len_ovf_o  (pad_len_ovf_o)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0]  msg_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] in_d_q[$];
    logic        in_lst_q[$];
    logic [2:0]  in_nb_q[$];
    bit          exp_ovf;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Message of n bytes: pat 0 random bytes, pat 1 repeating "abcd". Builds input beats and expected words.
    task automatic set_msg(input int n, input int pat);
        logic [7:0]  p[$];
        logic [63:0] bitlen;
        logic [63:0] mask;
        int          nw;
        msg_q.delete(); exp_q.delete(); in_d_q.delete(); in_lst_q.delete(); in_nb_q.delete();
        for (int i = 0; i < n; i++)
            msg_q.push_back(pat == 1 ? 8'(8'h61 + (i % 4)) : 8'($urandom_range(0, 255)));
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        mask   = (LEN_W >= 64) ? '1 : ((64'd1 << LEN_W) - 64'd1);
        bitlen = (64'(n) * 64'd8) & mask;
        exp_ovf = (LEN_W < 64) && ((64'(n) * 64'd8) > mask);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bitlen >> (8 * i)));
        for (int w = 0; w < p.size() / 4; w++)
            exp_q.push_back({p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]});
        nw = (n == 0) ? 1 : (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] word;
            word = $urandom();
            for (int b = 0; b < 4; b++)
                if (4 * w + b < n) word[31 - 8*b -: 8] = msg_q[4*w + b];
            in_d_q.push_back(word);
            in_lst_q.push_back(w == nw - 1);
            in_nb_q.push_back((w == nw - 1) ? 3'(n - 4 * w) : 3'd4);
        end
    endtask

    // Stream one message; abort_after>0 pulses reset once that many padded words are out in the pad phase.
    task automatic run_msg(input int rdy_pct, input int abort_after);
        int          ii = 0;
        int          oi = 0;
        int          cyc = 0;
        bit          in_done = 0;
        bit          in_hold = 0;
        bit          hold_o = 0;
        logic [31:0] prev_d = '0;
        logic        prev_lst = 1'b0;
        while (oi < exp_q.size() && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (!in_hold) begin
                if (ii < in_d_q.size() && $urandom_range(0, 3) != 0) begin
                    msg_inpt_vld_i = 1'b1;
                    msg_inpt_d_i   = in_d_q[ii];
                    msg_inpt_lst_i = in_lst_q[ii];
                    msg_inpt_nb_i  = in_nb_q[ii];
                end else begin
                    msg_inpt_vld_i = 1'b0;
                    msg_inpt_d_i   = $urandom();
                    msg_inpt_lst_i = 1'($urandom_range(0, 1));
                end
            end
            pad_otpt_rdy_i = ($urandom_range(0, 99) < rdy_pct);
            @(negedge clk);
            if (hold_o) begin
                check_val("hold_vld", pad_otpt_vld_o, 1);
                check_val("hold_d", pad_otpt_d_o, prev_d);
                check_val("hold_lst", pad_otpt_lst_o, prev_lst);
            end
            if (in_done) check_val("msg_rdy_pad", msg_inpt_rdy_o, 0);
            if (pad_otpt_vld_o && pad_otpt_rdy_i) begin
                check_val($sformatf("word%0d", oi), pad_otpt_d_o, exp_q[oi]);
                check_val($sformatf("lst%0d", oi), pad_otpt_lst_o, (oi == exp_q.size() - 1));
                oi++;
            end
            if (msg_inpt_vld_i && msg_inpt_rdy_o) begin
                ii++;
                if (ii == in_d_q.size()) in_done = 1;
            end
            in_hold  = msg_inpt_vld_i && !msg_inpt_rdy_o;
            hold_o   = pad_otpt_vld_o && !pad_otpt_rdy_i;
            prev_d   = pad_otpt_d_o;
            prev_lst = pad_otpt_lst_o;
            if (abort_after > 0 && in_done && oi >= abort_after) begin
                msg_inpt_vld_i = 1'b0;
                rst_n = 1'b0;
                #1;
                check_val("rst_vld", pad_otpt_vld_o, 0);
                check_val("rst_lst", pad_otpt_lst_o, 0);
                check_val("rst_rdy", msg_inpt_rdy_o, pad_otpt_rdy_i);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
        end
        check_val("word_count", oi, exp_q.size());
        msg_inpt_vld_i = 1'b0;
`ifdef SM3_PAD_LEN_OVF_EN
        check_val("len_ovf", pad_len_ovf_o, exp_ovf);
`endif
    endtask

    initial begin
        rst_n          = 1'b0;
        msg_inpt_d_i   = 32'h1234_5678;
        msg_inpt_vld_i = 1'b0;
        msg_inpt_lst_i = 1'b0;
        msg_inpt_nb_i  = 3'd0;
        pad_otpt_rdy_i = 1'b1;
        #12;
        check_val("rst_vld0", pad_otpt_vld_o, 0);
        check_val("rst_lst0", pad_otpt_lst_o, 0);
        check_val("rst_rdy0", msg_inpt_rdy_o, 1);
        check_val("rst_d0", pad_otpt_d_o, 32'h1234_5678);
        @(posedge clk); #1;
        rst_n = 1'b1;

        set_msg(3, 1);  run_msg(100, 0);   // "abc"
        set_msg(0, 0);  run_msg(100, 0);   // empty
        set_msg(55, 0); run_msg(100, 0);
        set_msg(56, 0); run_msg(100, 0);
        set_msg(64, 1); run_msg(50, 0);
        set_msg(10, 0); run_msg(70, 6);    // reset pulse during zero fill
        set_msg(3, 1);  run_msg(100, 0);
`ifdef SM3_PAD_LEN_OVF_EN
        set_msg(36, 0); run_msg(100, 0);
        set_msg(3, 1);  run_msg(100, 0);
`endif
        for (int k = 0; k < 20; k++) begin
            set_msg(int'($urandom_range(0, 150)), 0);
            run_msg(int'($urandom_range(30, 100)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
